// File: rtl/educore_unified_memory_pkg.sv
// Shared definitions for the Educore unified memory:
// access sizes, idle fetch word and loader states.
package educore_unified_memory_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [31:0] NOP_WORD_DEF = 32'hD503201F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } ld_state_e;

    // Byte enables for an access of size s, lane 0 first.
    function automatic logic [7:0] size_be(input logic [1:0] s);
        return {{4{&s}}, {2{s[1]}}, |s, 1'b1};
    endfunction

endpackage

// File: rtl/educore_unified_memory_bank.sv
// 8-lane byte RAM with one write port and two asynchronous
// read ports; rotates lanes so any byte address is legal.
module educore_mem_bank #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [63:0]       wd_i,
    input  logic [7:0]        wbe_i,
    input  logic [ADDR_W-1:0] fa_i,
    output logic [31:0]       fd_o,
    input  logic [ADDR_W-1:0] da_i,
    output logic [63:0]       dd_o
);

    localparam int ROW_W = ADDR_W - 3;
    localparam int DEPTH = 1 << ROW_W;

    logic [7:0] flane [8];
    logic [7:0] dlane [8];

    // Lanes below the start offset belong to the next row.
    for (genvar j = 0; j < 8; j++) begin : g_lane
        logic [7:0]       ram_q [DEPTH];
        logic [2:0]       wi;
        logic [ROW_W-1:0] wrow;
        logic [ROW_W-1:0] frow;
        logic [ROW_W-1:0] drow;

        assign wi   = 3'(j) - wa_i[2:0];
        assign wrow = wa_i[ADDR_W-1:3]
                    + ROW_W'(3'(j) < wa_i[2:0]);
        assign frow = fa_i[ADDR_W-1:3]
                    + ROW_W'(3'(j) < fa_i[2:0]);
        assign drow = da_i[ADDR_W-1:3]
                    + ROW_W'(3'(j) < da_i[2:0]);

        always_ff @(posedge clk) begin
            if (we_i && wbe_i[wi]) begin
                ram_q[wrow] <= wd_i[8*wi +: 8];
            end
        end

        assign flane[j] = ram_q[frow];
        assign dlane[j] = ram_q[drow];
    end

    always_comb begin
        fd_o = '0;
        dd_o = '0;
        for (int i = 0; i < 8; i++) begin
            dd_o[8*i +: 8] = dlane[3'(da_i[2:0] + 3'(i))];
        end
        for (int i = 0; i < 4; i++) begin
            fd_o[8*i +: 8] = flane[3'(fa_i[2:0] + 3'(i))];
        end
    end

endmodule

// File: rtl/educore_unified_memory.sv
// Unified fetch/data memory for Educore with a streaming
// program loader that holds the core until the image is in.
module educore_unified_memory
    import educore_unified_memory_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_wrap,
    output logic        core_run,
    input  logic        instruction_memory_en,
    input  logic [63:0] instruction_memory_a,
    output logic [31:0] instruction_memory_v,
    input  logic [63:0] data_memory_a,
    input  logic [1:0]  data_memory_s,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    input  logic [63:0] data_memory_out_v,
    output logic [63:0] data_memory_in_v
);

    localparam logic [ADDR_W-1:0] PTR_TOP = ~ADDR_W'(3);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_q, wrap_d;
    logic [31:0]       instr_q;
    logic [63:0]       din_q;

    logic              run;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [63:0]       wd;
    logic [7:0]        wbe;
    logic [31:0]       fd;
    logic [63:0]       dd;
    logic              unused_addr;

    assign unused_addr = ^{instruction_memory_a[63:ADDR_W],
                           data_memory_a[63:ADDR_W]};

    assign run        = (state_q == ST_RUN);
    assign load_ready = (state_q == ST_LOAD);
    assign core_run   = run;
    assign load_wrap  = wrap_q;

    assign instruction_memory_v = instr_q;
    assign data_memory_in_v     = din_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_valid) begin
                    ptr_d = ptr_q + ADDR_W'(4);
                    if (ptr_q == PTR_TOP) begin
                        wrap_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader and core never own the write port at the same time.
    always_comb begin
        we  = load_valid && load_ready;
        wa  = ptr_q;
        wd  = {32'b0, load_data};
        wbe = 8'h0F;
        if (run) begin
            we  = data_memory_write;
            wa  = data_memory_a[ADDR_W-1:0];
            wd  = data_memory_out_v;
            wbe = size_be(data_memory_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
            instr_q <= NOP_WORD;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
            if (run && instruction_memory_en) begin
                instr_q <= fd;
            end
            if (run && data_memory_read) begin
                din_q <= dd;
            end
        end
    end

    educore_mem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we_i  (we),
        .wa_i  (wa),
        .wd_i  (wd),
        .wbe_i (wbe),
        .fa_i  (instruction_memory_a[ADDR_W-1:0]),
        .fd_o  (fd),
        .da_i  (data_memory_a[ADDR_W-1:0]),
        .dd_o  (dd)
    );

endmodule

// File: tb/tb_educore_unified_memory.sv
// Self-checking bench: directed vector table, full-memory
// wrap load, then random traffic against a byte-array model.
module tb_educore_unified_memory;

    localparam int          MSZ = 1 << 16;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_wrap;
    logic        core_run;
    logic        im_en;
    logic [63:0] im_a;
    logic [31:0] im_v;
    logic [63:0] dm_a;
    logic [1:0]  dm_s;
    logic        dm_rd;
    logic        dm_wr;
    logic [63:0] dm_out;
    logic [63:0] dm_in;

    educore_unified_memory dut (
        .clk                   (clk),
        .reset                 (reset),
        .load_valid            (load_valid),
        .load_data             (load_data),
        .load_last             (load_last),
        .load_ready            (load_ready),
        .load_wrap             (load_wrap),
        .core_run              (core_run),
        .instruction_memory_en (im_en),
        .instruction_memory_a  (im_a),
        .instruction_memory_v  (im_v),
        .data_memory_a         (dm_a),
        .data_memory_s         (dm_s),
        .data_memory_read      (dm_rd),
        .data_memory_write     (dm_wr),
        .data_memory_out_v     (dm_out),
        .data_memory_in_v      (dm_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    bit [7:0]  mm [MSZ];
    bit [15:0] mptr;

    typedef struct {
        string       nm;
        logic        fe;
        logic [63:0] fa;
        logic        re;
        logic        we;
        logic [63:0] a;
        logic [1:0]  s;
        logic [63:0] wd;
        logic [63:0] din;
        logic [31:0] ins;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load_valid = 0;
        load_data  = '0;
        load_last  = 0;
        im_en      = 0;
        im_a       = '0;
        dm_a       = '0;
        dm_s       = '0;
        dm_rd      = 0;
        dm_wr      = 0;
        dm_out     = '0;
    endtask

    function automatic logic [63:0] m_rd(input logic [63:0] a,
                                         input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[8*i +: 8] = mm[16'(a[15:0] + 16'(i))];
        end
        return r;
    endfunction

    task automatic m_wr(input logic [63:0] a, input logic [1:0] s,
                        input logic [63:0] d);
        int n = 1 << s;
        for (int i = 0; i < n; i++) begin
            mm[16'(a[15:0] + 16'(i))] = d[8*i +: 8];
        end
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        int n = 0;
        while (!load_ready && n < 8) begin
            step();
            n++;
        end
        if (!load_ready) begin
            checks++;
            errs++;
            $display("FAIL ld_timeout: got %b expected 1", load_ready);
        end
        load_valid = 1;
        load_data  = w;
        load_last  = last;
        step();
        load_valid = 0;
        load_last  = 0;
        for (int b = 0; b < 4; b++) begin
            mm[16'(mptr + 16'(b))] = w[8*b +: 8];
        end
        mptr = mptr + 16'd4;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        step();
        step();
        reset = 0;
        mptr  = '0;
    endtask

    function automatic vec_t mk(
        input string nm, input logic fe, input logic [63:0] fa,
        input logic re, input logic we, input logic [63:0] a,
        input logic [1:0] s, input logic [63:0] wd,
        input logic [63:0] din, input logic [31:0] ins);
        vec_t v;
        v.nm = nm; v.fe = fe; v.fa = fa; v.re = re; v.we = we;
        v.a = a; v.s = s; v.wd = wd; v.din = din; v.ins = ins;
        return v;
    endfunction

    initial begin
        logic [31:0] ins_m;
        logic [63:0] din_m;
        logic [1:0]  rs;
        logic [63:0] ra;

        vq.push_back(mk("fetch2", 1, 2, 0, 0, 0, 0, 0,
                        64'h0, 32'h77881122));
        vq.push_back(mk("fetch_hold", 0, 'h40, 0, 0, 0, 0, 0,
                        64'h0, 32'h77881122));
        vq.push_back(mk("rd0", 0, 0, 1, 0, 0, 0, 0,
                        64'h5566778811223344, 32'h77881122));
        vq.push_back(mk("rd4_drop", 0, 0, 1, 0, 4, 0, 0,
                        64'h99AABBCC55667788, 32'h77881122));
        vq.push_back(mk("wr50_d", 0, 0, 0, 1, 'h50, 3,
                        64'h0102030405060708,
                        64'h99AABBCC55667788, 32'h77881122));
        vq.push_back(mk("wr50_b", 0, 0, 0, 1, 'h50, 0,
                        64'hAABBCCDDEEFF0011,
                        64'h99AABBCC55667788, 32'h77881122));
        vq.push_back(mk("rd50", 0, 0, 1, 0, 'h50, 0, 0,
                        64'h0102030405060711, 32'h77881122));
        vq.push_back(mk("wr_top", 0, 0, 0, 1, 64'hABCD00000000FFFC,
                        3, 64'h0807060504030201,
                        64'h0102030405060711, 32'h77881122));
        vq.push_back(mk("rd_top", 0, 0, 1, 0, 'hFFFC, 0, 0,
                        64'h0807060504030201, 32'h77881122));
        vq.push_back(mk("rd0_wrap", 1, 64'h123400000000FFFE, 1, 0,
                        0, 0, 0,
                        64'h5566778808070605, 32'h06050403));
        vq.push_back(mk("wr100_d", 0, 0, 0, 1, 'h100, 3,
                        64'h1122334455667788,
                        64'h5566778808070605, 32'h06050403));
        vq.push_back(mk("rw100_old", 1, 'h100, 1, 1, 'h100, 2,
                        64'hFFFFFFFFCAFEBABE,
                        64'h1122334455667788, 32'h55667788));
        vq.push_back(mk("rd100_new", 0, 0, 1, 0, 'h100, 0, 0,
                        64'h11223344CAFEBABE, 32'h55667788));
        vq.push_back(mk("wr103_h", 0, 0, 0, 1, 'h103, 1,
                        64'h000000000000BEEF,
                        64'h11223344CAFEBABE, 32'h55667788));
        vq.push_back(mk("rd100_h", 0, 0, 1, 0, 'h100, 0, 0,
                        64'h112233BEEFFEBABE, 32'h55667788));

        do_reset();
        reset = 1;
        step();
        chk("rst_ready", load_ready, 0);
        chk("rst_run", core_run, 0);
        chk("rst_wrap", load_wrap, 0);
        chk("rst_instr", im_v, NOP);
        chk("rst_din", dm_in, 0);
        reset = 0;
        step();
        chk("idle_to_load", load_ready, 1);

        // First, interrupted load with a gap and a dropped core write.
        load_word(32'hDEADBEEF, 0);
        load_word(32'h01234567, 0);
        im_en  = 1;
        im_a   = 0;
        dm_rd  = 1;
        dm_wr  = 1;
        dm_a   = 8;
        dm_s   = 2'b10;
        dm_out = '1;
        step();
        idle_in();
        chk("load_nop", im_v, NOP);
        chk("load_din", dm_in, 0);
        chk("load_run", core_run, 0);
        load_word(32'h99AABBCC, 0);
        reset = 1;
        step();
        reset = 0;
        chk("midrst_run", core_run, 0);
        chk("midrst_instr", im_v, NOP);
        chk("midrst_ready", load_ready, 0);
        mptr = '0;
        step();

        load_word(32'h11223344, 0);
        chk("run_before_last", core_run, 0);
        load_word(32'h55667788, 1);
        chk("run_after_last", core_run, 1);
        chk("ready_after_last", load_ready, 0);
        step();
        chk("ready_stays_low", load_ready, 0);
        chk("nowrap_small", load_wrap, 0);

        foreach (vq[k]) begin
            im_en  = vq[k].fe;
            im_a   = vq[k].fa;
            dm_rd  = vq[k].re;
            dm_wr  = vq[k].we;
            dm_a   = vq[k].a;
            dm_s   = vq[k].s;
            dm_out = vq[k].wd;
            step();
            chk({vq[k].nm, "_din"}, dm_in, vq[k].din);
            chk({vq[k].nm, "_ins"}, im_v, vq[k].ins);
        end
        idle_in();

        // Fill all of memory, wrapping once, with random gaps.
        do_reset();
        step();
        for (int k = 0; k < MSZ / 4; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                step();
            end
            if (k == MSZ / 4 - 1) begin
                chk("wrap_before", load_wrap, 0);
            end
            load_word(32'(k) * 32'h9E3779B9 ^ 32'h5A5A5A5A, 0);
        end
        chk("wrap_after", load_wrap, 1);
        chk("wrap_not_run", core_run, 0);
        load_word(32'h13579BDF, 1);
        chk("wrap_run", core_run, 1);
        chk("wrap_sticky", load_wrap, 1);

        ins_m = NOP;
        din_m = '0;
        for (int t = 0; t < 400; t++) begin
            im_en  = 1'($urandom_range(0, 1));
            im_a   = {$urandom, $urandom};
            dm_rd  = 1'($urandom_range(0, 1));
            dm_wr  = ($urandom_range(0, 2) == 0);
            ra     = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                ra[15:0] = 16'hFFF8 + 16'($urandom_range(0, 7));
            end
            rs     = 2'($urandom_range(0, 3));
            dm_a   = ra;
            dm_s   = rs;
            dm_out = {$urandom, $urandom};
            if (im_en) ins_m = m_rd(im_a, 4)[31:0];
            if (dm_rd) din_m = m_rd(dm_a, 8);
            if (dm_wr) m_wr(dm_a, dm_s, dm_out);
            step();
            chk("rnd_din", dm_in, din_m);
            chk("rnd_ins", im_v, ins_m);
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
